// File: rtl/fdtd_field_update.sv
// fdtd_field_update: streaming FDTD E-field update, 3-stage pipeline.
// Define FDTD_PEC_BOUNDARY_EN to force the first/last cell of a step to 0.
module fdtd_field_update #(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int COEF_WIDTH      = 16,
  parameter int FRAC_BITS       = 14,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              start_i,
  input  logic [CNT_WIDTH-1:0]              num_cells_i,
  input  logic signed [COEF_WIDTH-1:0]      coef_ca_i,
  input  logic signed [COEF_WIDTH-1:0]      coef_cb_i,
  input  logic signed [FDTD_DATA_WIDTH-1:0] e_data_i,
  input  logic signed [FDTD_DATA_WIDTH-1:0] h_data_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  output logic signed [FDTD_DATA_WIDTH-1:0] e_data_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic                              busy_o,
  output logic                              done_o
);
  localparam int W  = FDTD_DATA_WIDTH;
  localparam int C  = COEF_WIDTH;
  localparam int SW = W + C + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic [1:0]              state_q, state_d;
  logic [CNT_WIDTH-1:0]    rem_q, rem_d;
  logic signed [C-1:0]     ca_q, ca_d;
  logic signed [C-1:0]     cb_q, cb_d;
  logic signed [W-1:0]     hprev_q, hprev_d;
  logic                    s1_v_q, s1_v_d;
  logic signed [W-1:0]     s1_e_q, s1_e_d;
  logic signed [W:0]       s1_diff_q, s1_diff_d;
  logic                    s2_v_q, s2_v_d;
  logic signed [W+C-1:0]   s2_p1_q, s2_p1_d;
  logic signed [W+C:0]     s2_p2_q, s2_p2_d;
  logic                    ov_q, ov_d;
  logic signed [W-1:0]     eo_q, eo_d;
  logic                    done_q, done_d;
`ifdef FDTD_PEC_BOUNDARY_EN
  logic [CNT_WIDTH-1:0]    idx_q, idx_d;
  logic                    s1_first_q, s1_first_d;
  logic                    s1_last_q, s1_last_d;
  logic                    s2_first_q, s2_first_d;
  logic                    s2_last_q, s2_last_d;
`endif

  logic                    adv;
  logic                    xfer;
  logic signed [SW-1:0]    sum;
  logic signed [SW-1:0]    shd;
  logic [SW-W:0]           top;
  logic signed [W-1:0]     sat;

  always_comb begin
    adv        = out_ready_i || !ov_q;
    in_ready_o = (state_q == S_RUN) && adv && (rem_q != '0);
    xfer       = in_valid_i && in_ready_o;

    sum = SW'(s2_p1_q) + SW'(s2_p2_q);
    shd = sum >>> FRAC_BITS;
    top = shd[SW-1:W-1];
    // In range only when every bit above the result's sign bit agrees
    if (&top || ~|top) sat = shd[W-1:0];
    else if (top[SW-W]) sat = MINV;
    else sat = MAXV;

    state_d   = state_q;
    rem_d     = rem_q;
    ca_d      = ca_q;
    cb_d      = cb_q;
    hprev_d   = hprev_q;
    s1_v_d    = s1_v_q;
    s1_e_d    = s1_e_q;
    s1_diff_d = s1_diff_q;
    s2_v_d    = s2_v_q;
    s2_p1_d   = s2_p1_q;
    s2_p2_d   = s2_p2_q;
    ov_d      = ov_q;
    eo_d      = eo_q;
    done_d    = (state_q == S_DONE);
`ifdef FDTD_PEC_BOUNDARY_EN
    idx_d      = idx_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s2_first_d = s2_first_q;
    s2_last_d  = s2_last_q;
`endif

    case (state_q)
      S_IDLE: if (start_i) begin
        ca_d    = coef_ca_i;
        cb_d    = coef_cb_i;
        rem_d   = num_cells_i;
        hprev_d = '0;
`ifdef FDTD_PEC_BOUNDARY_EN
        idx_d   = '0;
`endif
        state_d = (num_cells_i != '0) ? S_RUN : S_DONE;
      end
      S_RUN: if (xfer && rem_q == CNT_WIDTH'(1)) state_d = S_DRAIN;
      S_DRAIN:
        if (ov_q && out_ready_i && !s1_v_q && !s2_v_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (xfer) begin
      hprev_d = h_data_i;
      rem_d   = rem_q - CNT_WIDTH'(1);
`ifdef FDTD_PEC_BOUNDARY_EN
      idx_d   = idx_q + CNT_WIDTH'(1);
`endif
    end

    if (adv) begin
      s1_v_d = xfer;
      if (xfer) begin
        s1_e_d    = e_data_i;
        s1_diff_d = (W+1)'(h_data_i) - (W+1)'(hprev_q);
`ifdef FDTD_PEC_BOUNDARY_EN
        s1_first_d = (idx_q == '0);
        s1_last_d  = (rem_q == CNT_WIDTH'(1));
`endif
      end
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_p1_d = (W+C)'(ca_q) * (W+C)'(s1_e_q);
        s2_p2_d = (W+C+1)'(cb_q) * (W+C+1)'(s1_diff_q);
`ifdef FDTD_PEC_BOUNDARY_EN
        s2_first_d = s1_first_q;
        s2_last_d  = s1_last_q;
`endif
      end
      ov_d = s2_v_q;
      if (s2_v_q) begin
`ifdef FDTD_PEC_BOUNDARY_EN
        eo_d = (s2_first_q || s2_last_q) ? '0 : sat;
`else
        eo_d = sat;
`endif
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      ca_q      <= '0;
      cb_q      <= '0;
      hprev_q   <= '0;
      s1_v_q    <= 1'b0;
      s1_e_q    <= '0;
      s1_diff_q <= '0;
      s2_v_q    <= 1'b0;
      s2_p1_q   <= '0;
      s2_p2_q   <= '0;
      ov_q      <= 1'b0;
      eo_q      <= '0;
      done_q    <= 1'b0;
`ifdef FDTD_PEC_BOUNDARY_EN
      idx_q      <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      ca_q      <= ca_d;
      cb_q      <= cb_d;
      hprev_q   <= hprev_d;
      s1_v_q    <= s1_v_d;
      s1_e_q    <= s1_e_d;
      s1_diff_q <= s1_diff_d;
      s2_v_q    <= s2_v_d;
      s2_p1_q   <= s2_p1_d;
      s2_p2_q   <= s2_p2_d;
      ov_q      <= ov_d;
      eo_q      <= eo_d;
      done_q    <= done_d;
`ifdef FDTD_PEC_BOUNDARY_EN
      idx_q      <= idx_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s2_first_q <= s2_first_d;
      s2_last_q  <= s2_last_d;
`endif
    end
  end

  assign e_data_o    = eo_q;
  assign out_valid_o = ov_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: doc/fdtd_field_update.md
Name: fdtd_field_update

Overview:
- Streaming E-field update stage for the FDTD engine.
- Consumes paired E/H cell samples for one time step and computes E_new[k] = sat((ca*E[k] + cb*(H[k]-H[k-1])) >>> FRAC_BITS).
- Emits one result per cell through a 3-stage pipeline.
- Its output feeds the downstream fixed data-delay stage, which aligns E with the following H-update path.

Parameters:
FDTD_DATA_WIDTH, 32, signed width of E/H samples and of the result
COEF_WIDTH, 16, signed width of coefficients ca/cb
FRAC_BITS, 14, fractional bits of coefficients; right-shift amount applied to the sum
CNT_WIDTH, 16, width of the cell counter and of num_cells_i

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
start_i  input  1  start one time step; sampled only in IDLE
num_cells_i  input  CNT_WIDTH  cells in this step; latched on start_i
coef_ca_i  input  COEF_WIDTH  ca, signed; latched on start_i
coef_cb_i  input  COEF_WIDTH  cb, signed; latched on start_i
e_data_i  input  FDTD_DATA_WIDTH  E[k], signed
h_data_i  input  FDTD_DATA_WIDTH  H[k], signed
in_valid_i  input  1  E/H pair valid
in_ready_o  output  1  stage accepts a pair this cycle
e_data_o  output  FDTD_DATA_WIDTH  E_new[k], signed
out_valid_o  output  1  e_data_o valid
out_ready_i  input  1  downstream accepts
busy_o  output  1  high outside IDLE
done_o  output  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (asynchronous, active-high): FSM goes to IDLE; all pipeline valids clear; counters clear; H-previous register clears. Outputs reset as follows: e_data_o=0, out_valid_o=0, in_ready_o=0, busy_o=0, done_o=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start_i, latch num_cells_i, ca and cb; clear remaining-input count to num_cells_i; clear cell index and hprev to 0.
  - IDLE to RUN when num_cells_i>0. IDLE to DONE when num_cells_i=0 (no outputs are produced).
  - RUN to DRAIN when the last input is accepted.
  - DRAIN to DONE when the last output handshake completes (out_valid_o && out_ready_i on the final cell).
  - DONE: asserts done_o for one cycle, then returns to IDLE.
  - start_i is ignored outside IDLE.
- Pipeline advance: adv = out_ready_i || !out_valid_o. All stages hold when adv=0. Stall is global across stages, with no bubbles squeezed out.
- Input handshake:
  - in_ready_o = (state==RUN) && adv && remaining>0.
  - Transfer occurs when in_valid_i && in_ready_o.
  - On transfer, hprev<=h_data_i, remaining decrements and the cell index increments.
- Stage 1: registers e, diff = h - hprev (sign-extended to FDTD_DATA_WIDTH+1; the first cell uses hprev=0), a first flag, a last flag and valid.
- Stage 2: p1 = ca*e and p2 = cb*diff, full-precision signed.
- Stage 3:
  - s = p1+p2 at full width (FDTD_DATA_WIDTH+COEF_WIDTH+2 bits).
  - Arithmetic shift >>> FRAC_BITS, truncating toward -inf.
  - Saturate to [-2^(W-1), 2^(W-1)-1].
  - Register into e_data_o and set out_valid_o.
- Latency: 3 cycles from input acceptance to out_valid_o when out_ready_i is held high. Throughput is 1 per cycle.
- While out_valid_o=1 and out_ready_i=0: e_data_o and out_valid_o hold stable.
- Reset mid-step: all in-flight data is discarded and done_o is not pulsed.

Optional Feature:
- Macro FDTD_PEC_BOUNDARY_EN.
- Defined: the first and last cells of a step (index 0 and num_cells-1) output 0, which is the PEC wall. Flags travel with the data through the pipeline. With num_cells=1, the single cell outputs 0.
- Undefined: boundary cells are computed like interior cells. The first and last flags are not implemented.

Test Plan:
- Interior update, macro undefined:
  - Stimulus: ca=16384, cb=8192, N=4, E=[100,200,300,400], H=[10,30,60,100], out_ready_i=1.
  - Required: outputs [105,210,315,420]; first output exactly 3 cycles after first acceptance; done_o pulses once.
- PEC boundary, macro defined:
  - Stimulus: same as the interior test.
  - Required: outputs [0,210,315,0].
- Saturation:
  - Positive: ca=16384, cb=16384, E=0x7FFFFFF0, diff=+100 gives 0x7FFFFFFF.
  - Negative: E=0x80000000, diff=-1 gives 0x80000000.
- Truncation toward -inf:
  - Stimulus: ca=0, cb=8192, N=1, H=[-1].
  - Required: output 0xFFFFFFFF (-1), macro undefined.
- Backpressure:
  - Stimulus: N=4 with out_ready_i low for cycles 4-7.
  - Required: e_data_o holds 105 stable; in_ready_o=0 throughout the stall; no loss or duplication; final sequence unchanged.
- Zero length and reset:
  - num_cells=0 with start gives done_o 2 cycles later and no out_valid_o.
  - RST asserted mid-DRAIN clears out_valid_o, busy_o and done_o immediately; the next start behaves normally.
